// File: rtl/rf_arb_pkg.sv
// ============================================================================
// Module  : rf_arb_pkg
// Brief   : Shared widths and writeback entry type for the RF write arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int XLEN    = 32;
    localparam int AW      = 5;
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic            full;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_slot.sv
// ============================================================================
// Module  : rf_wb_slot
// Brief   : One-entry writeback holding slot; ready while empty or draining.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_wb_slot #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            v,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] d,
    input  logic            gnt,
    output logic            rdy,
    output logic            full,
    output logic [AW-1:0]   rd_out,
    output logic [XLEN-1:0] d_out
);

    logic            full_q, full_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            accept;

    // Ready depends only on registered state and the grant, never on v.
    assign rdy    = ~full_q | gnt;
    assign accept = v & rdy;

    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            rd_d   = rd;
            data_d = d;
        end else if (gnt) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign full   = full_q;
    assign rd_out = rd_q;
    assign d_out  = data_q;

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module  : rf_write_arbiter
// Brief   : Two-port round-robin register-file write arbiter with registered
//           RF write outputs. Optional pending map under RF_ARB_PEND_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN = rf_arb_pkg::XLEN,
    parameter int AW   = rf_arb_pkg::AW
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               V0,
    input  logic               V1,
    input  logic [AW-1:0]      RD0,
    input  logic [AW-1:0]      RD1,
    input  logic [XLEN-1:0]    D0,
    input  logic [XLEN-1:0]    D1,
    output logic               RDY0,
    output logic               RDY1,
`ifdef RF_ARB_PEND_EN
    output logic [2**AW-1:0]   PEND_RF,
`endif
    output logic               WE_RF,
    output logic [AW-1:0]      RW_RF,
    output logic [XLEN-1:0]    DW_RF
);

    logic [NUM_REQ-1:0] v_in, full, gnt, rdy;
    logic [AW-1:0]      rd_in   [NUM_REQ];
    logic [AW-1:0]      rd_slot [NUM_REQ];
    logic [XLEN-1:0]    d_in    [NUM_REQ];
    logic [XLEN-1:0]    d_slot  [NUM_REQ];

    logic               ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [AW-1:0]      rw_q, rw_d;
    logic [XLEN-1:0]    dw_q, dw_d;
    logic               gsel;

    assign v_in     = {V1, V0};
    assign rd_in[0] = RD0;
    assign rd_in[1] = RD1;
    assign d_in[0]  = D0;
    assign d_in[1]  = D1;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
            rf_wb_slot #(
                .XLEN (XLEN),
                .AW   (AW)
            ) u_slot (
                .clk    (CLK),
                .rst_n  (RES),
                .v      (v_in[i]),
                .rd     (rd_in[i]),
                .d      (d_in[i]),
                .gnt    (gnt[i]),
                .rdy    (rdy[i]),
                .full   (full[i]),
                .rd_out (rd_slot[i]),
                .d_out  (d_slot[i])
            );
        end
    endgenerate

    assign RDY0 = rdy[0];
    assign RDY1 = rdy[1];

    // The pointer only advances when both ports actually competed.
    always_comb begin
        gnt   = full;
        ptr_d = ptr_q;
        if (full[0] && full[1]) begin
            gnt        = '0;
            gnt[ptr_q] = 1'b1;
            ptr_d      = ~ptr_q;
        end
    end

    assign gsel = gnt[1];

    always_comb begin
        we_d = 1'b0;
        rw_d = rw_q;
        dw_d = dw_q;
        if (|gnt) begin
            we_d = (rd_slot[gsel] != '0);
            rw_d = rd_slot[gsel];
            dw_d = d_slot[gsel];
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            ptr_q <= 1'b0;
            we_q  <= 1'b0;
            rw_q  <= '0;
            dw_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= we_d;
            rw_q  <= rw_d;
            dw_q  <= dw_d;
        end
    end

    assign WE_RF = we_q;
    assign RW_RF = rw_q;
    assign DW_RF = dw_q;

`ifdef RF_ARB_PEND_EN
    logic [2**AW-1:0] pend;

    // Output stage counts as pending only while its write is being driven.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full[i]) pend[rd_slot[i]] = 1'b1;
        end
        if (we_q) pend[rw_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign PEND_RF = pend;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module  : tb_rf_write_arbiter
// Brief   : Directed bench for rf_write_arbiter with a register-file model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    logic        CLK, RES;
    logic        V0, V1;
    logic [4:0]  RD0, RD1;
    logic [31:0] D0, D1;
    logic        RDY0, RDY1, WE_RF;
    logic [4:0]  RW_RF;
    logic [31:0] DW_RF;
`ifdef RF_ARB_PEND_EN
    logic [31:0] PEND_RF;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rf [32];

    rf_write_arbiter #(.XLEN(32), .AW(5)) dut (
        .CLK     (CLK),
        .RES     (RES),
        .V0      (V0),
        .V1      (V1),
        .RD0     (RD0),
        .RD1     (RD1),
        .D0      (D0),
        .D1      (D1),
        .RDY0    (RDY0),
        .RDY1    (RDY1),
`ifdef RF_ARB_PEND_EN
        .PEND_RF (PEND_RF),
`endif
        .WE_RF   (WE_RF),
        .RW_RF   (RW_RF),
        .DW_RF   (DW_RF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file deliberately not hardwiring x0, so stray writes show up.
    always @(posedge CLK) begin
        if (WE_RF) rf[RW_RF] <= DW_RF;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RES = 1'b1; V0 = 0; V1 = 0; RD0 = 0; RD1 = 0; D0 = 0; D1 = 0;
        #2 RES = 1'b0;
        #1;
        chk("rst_we", WE_RF, 0);
        chk("rst_rw", RW_RF, 0);
        chk("rst_dw", DW_RF, 0);
`ifdef RF_ARB_PEND_EN
        chk("rst_pend", PEND_RF, 0);
`endif
        tick(); tick();
        RES = 1'b1;
        chk("rel_rdy0", RDY0, 1);
        chk("rel_rdy1", RDY1, 1);

        // Single write, port 0
        V0 = 1; RD0 = 5; D0 = 32'h4B;
        chk("t1_rdy0", RDY0, 1);
        tick();
        V0 = 0;
        chk("t1_we_k", WE_RF, 0);
        tick();
        chk("t1_we", WE_RF, 1);
        chk("t1_rw", RW_RF, 5);
        chk("t1_dw", DW_RF, 32'h4B);
        tick();
        chk("t1_we_off", WE_RF, 0);
        chk("t1_rw_hold", RW_RF, 5);
        chk("t1_rf5", rf[5], 32'h4B);

        // Both ports held: alternate grants, one write per cycle
        V0 = 1; RD0 = 3; D0 = 32'h11;
        V1 = 1; RD1 = 7; D1 = 32'h22;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t2_we", WE_RF, 1);
            chk("t2_rw", RW_RF, (i % 2 == 1) ? 3 : 7);
            chk("t2_dw", DW_RF, (i % 2 == 1) ? 32'h11 : 32'h22);
            chk("t2_rdy0", RDY0, (i % 2 == 1) ? 0 : 1);
            chk("t2_rdy1", RDY1, (i % 2 == 1) ? 1 : 0);
        end
        V0 = 0; V1 = 0;
        tick();
        chk("t2_tail0", RW_RF, 3);
        tick();
        chk("t2_tail1", RW_RF, 7);
        chk("t2_tail1_we", WE_RF, 1);
        tick();
        chk("t2_idle", WE_RF, 0);

        // Same RD in both slots with pointer at port 1
        V0 = 1; RD0 = 9; D0 = 32'hA;
        V1 = 1; RD1 = 9; D1 = 32'hB;
        tick();
        V0 = 0; V1 = 0;
        chk("t3_rdy0", RDY0, 0);
        chk("t3_rdy1", RDY1, 1);
        tick();
        chk("t3_first", DW_RF, 32'hB);
        tick();
        chk("t3_second", DW_RF, 32'hA);
        chk("t3_rf9_mid", rf[9], 32'hB);
        tick();
        chk("t3_we_off", WE_RF, 0);
        chk("t3_rf9", rf[9], 32'hA);

        // Write to x0 consumes a grant but never enables the RF
        V1 = 1; RD1 = 0; D1 = 32'hFFFF_FFFF;
        chk("t4_rdy1", RDY1, 1);
        tick();
        V1 = 0;
        tick();
        chk("t4_we", WE_RF, 0);
        chk("t4_dw", DW_RF, 32'hFFFF_FFFF);
        chk("t4_rdy1_after", RDY1, 1);
        tick();
        chk("t4_we2", WE_RF, 0);
        chk("t4_rf0", rf[0], 0);

        // Pending map for register 12
        V0 = 1; RD0 = 12; D0 = 32'hC;
`ifdef RF_ARB_PEND_EN
        chk("t6_pend_pre", PEND_RF[12], 0);
`endif
        tick();
        V0 = 0;
`ifdef RF_ARB_PEND_EN
        chk("t6_pend_acc", PEND_RF[12], 1);
`endif
        tick();
        chk("t6_we", WE_RF, 1);
`ifdef RF_ARB_PEND_EN
        chk("t6_pend_we", PEND_RF[12], 1);
`endif
        tick();
        chk("t6_we_off", WE_RF, 0);
        chk("t6_rf12", rf[12], 32'hC);
`ifdef RF_ARB_PEND_EN
        chk("t6_pend_clr", PEND_RF, 0);
`endif

        // Reset mid-operation discards buffered writes
        V0 = 1; RD0 = 4; D0 = 32'h44;
        V1 = 1; RD1 = 6; D1 = 32'h66;
        tick();
        tick();
        chk("t5_we_pre", WE_RF, 1);
        chk("t5_rw_pre", RW_RF, 4);
        #2 RES = 1'b0;
        #1;
        chk("t5_we_rst", WE_RF, 0);
        chk("t5_rw_rst", RW_RF, 0);
        chk("t5_dw_rst", DW_RF, 0);
        chk("t5_rdy0_rst", RDY0, 1);
        chk("t5_rdy1_rst", RDY1, 1);
`ifdef RF_ARB_PEND_EN
        chk("t5_pend_rst", PEND_RF, 0);
`endif
        V0 = 0; V1 = 0;
        tick();
        RES = 1'b1;
        chk("t5_rdy0_rel", RDY0, 1);
        chk("t5_rdy1_rel", RDY1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_write", WE_RF, 0);
        end
        chk("t5_rf4", rf[4], 0);
        chk("t5_rf6", rf[6], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
